// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single full-adder cell; the serial adder reuses it once per bit position over time.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN (adds port sub).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             accept;
  logic             last_bit;
  logic             s_bit;
  logic             co_bit;

  // Subtraction is a + ~b + 1, so only the loaded operand and initial carry differ.
`ifdef SERIAL_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign accept   = in_valid && (state_q == IDLE);
  assign last_bit = (cnt_q == LAST_BIT);

  fa_cell u_fa (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .cin(carry_q),
    .s  (s_bit),
    .co (co_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Counter holds on the final bit so it never wraps within an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          res_q   <= {s_bit, res_q[WIDTH-1:1]};
          carry_q <= co_bit;
          if (last_bit) begin
            ovf_q <= carry_q ^ co_bit;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = res_q;
  assign cout      = carry_q;
  assign overflow  = ovf_q;

endmodule
